// File: rtl/seg_buffer_viewer_if.sv
// Bus bundle for seg_buffer_viewer: debounced button pulses and flattened
// buffer contents in, display pins and viewer status out.
interface seg_buffer_viewer_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO      = 4,
  parameter int NUM_CH    = 2
);
  localparam int NUM_AN = DATA_BITS / 4 + 2;
  localparam int PW     = $clog2(FIFO);
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                            btn_prev;
  logic                            btn_next;
  logic                            btn_ch;
  logic                            btn_auto;
  logic [NUM_CH*FIFO*DATA_BITS-1:0] buf_flat;
  logic [6:0]                      seg;
  logic [NUM_AN-1:0]               an;
  logic                            dp;
  logic [PW-1:0]                   page_idx;
  logic [CW-1:0]                   ch_idx;
  logic                            auto_on;

  modport master (
    output btn_prev, btn_next, btn_ch, btn_auto, buf_flat,
    input  seg, an, dp, page_idx, ch_idx, auto_on
  );

  modport slave (
    input  btn_prev, btn_next, btn_ch, btn_auto, buf_flat,
    output seg, an, dp, page_idx, ch_idx, auto_on
  );
endinterface

// File: rtl/seg_buffer_viewer.sv
// Multi-channel FIFO viewer on a multiplexed hex display.
// Digits: entry nibbles (LS first), page index, channel tag ('t', 'r', hex).
// Optional macro SEG_DP_AUTO_EN: light the decimal point on the page digit
// while auto-scroll is active; otherwise dp stays dark.
module seg_buffer_viewer #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO        = 4,
  parameter int NUM_CH      = 2,
  parameter int REFRESH_DIV = 100000,
  parameter int AUTO_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  seg_buffer_viewer_if.slave  bus
);
  localparam int NUM_AN = DATA_BITS / 4 + 2;
  localparam int NIB    = DATA_BITS / 4;
  localparam int PW     = $clog2(FIFO);
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW     = $clog2(NUM_AN);
  localparam int DW     = $clog2(REFRESH_DIV);
  localparam int FW     = $clog2(AUTO_FRAMES + 1);

  logic [DW-1:0]        presc_q;
  logic [SW-1:0]        slot_q;
  logic [FW-1:0]        frame_q;
  logic [PW-1:0]        page_q;
  logic [CW-1:0]        ch_q;
  logic                 auto_q;
  logic [6:0]           seg_q;
  logic [NUM_AN-1:0]    an_q;

  logic                 presc_tc;
  logic                 frame_end;
  logic                 manual;
  logic                 auto_step;
  logic [PW-1:0]        page_d;
  logic [CW-1:0]        ch_d;
  logic [FW-1:0]        frame_d;
  logic                 auto_d;
  logic [DATA_BITS-1:0] entry;
  logic [4:0]           code;
  logic [6:0]           glyph;
  logic [NUM_AN-1:0]    an_d;

  // Scan timing: end of a digit slot and end of a full frame
  always_comb begin
    presc_tc  = (presc_q == DW'(REFRESH_DIV - 1));
    frame_end = presc_tc && (slot_q == SW'(NUM_AN - 1));
  end

  // Navigation: manual page step beats auto step; btn_auto toggles and restarts frame count
  always_comb begin
    page_d    = page_q;
    ch_d      = ch_q;
    frame_d   = frame_q;
    auto_d    = auto_q;
    auto_step = 1'b0;
    manual    = bus.btn_prev ^ bus.btn_next;
    if (bus.btn_auto) begin
      auto_d  = ~auto_q;
      frame_d = '0;
    end else if (manual) begin
      frame_d = '0;
    end else if (auto_q && frame_end) begin
      if (frame_q == FW'(AUTO_FRAMES - 1)) begin
        frame_d   = '0;
        auto_step = 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    if (manual)
      page_d = bus.btn_next ? page_q + 1'b1 : page_q - 1'b1;
    else if (auto_step)
      page_d = page_q + 1'b1;
    if (bus.btn_ch)
      ch_d = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
  end

  // Select the viewed entry and the symbol for the active digit slot
  always_comb begin
    entry = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      for (int unsigned e = 0; e < FIFO; e++)
        if (ch_q == CW'(c) && page_q == PW'(e))
          entry = bus.buf_flat[(c*FIFO+e)*DATA_BITS +: DATA_BITS];
    code = 5'd31;
    for (int unsigned n = 0; n < NIB; n++)
      if (slot_q == SW'(n))
        code = {1'b0, entry[n*4 +: 4]};
    if (slot_q == SW'(NUM_AN - 2))
      code = 5'(page_q);
    if (slot_q == SW'(NUM_AN - 1)) begin
      if (ch_q == '0)
        code = 5'd16;
      else if (ch_q == CW'(1))
        code = 5'd17;
      else
        code = 5'(ch_q);
    end
    an_d = '1;
    for (int unsigned n = 0; n < NUM_AN; n++)
      an_d[n] = (slot_q != SW'(n));
  end

  // Symbol to active-low {g..a} cathode pattern; codes 16/17 are 't'/'r'
  always_comb begin
    case (code)
      5'd0:    glyph = 7'b1000000;
      5'd1:    glyph = 7'b1111001;
      5'd2:    glyph = 7'b0100100;
      5'd3:    glyph = 7'b0110000;
      5'd4:    glyph = 7'b0011001;
      5'd5:    glyph = 7'b0010010;
      5'd6:    glyph = 7'b0000010;
      5'd7:    glyph = 7'b1111000;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0010000;
      5'd10:   glyph = 7'b0001000;
      5'd11:   glyph = 7'b0000011;
      5'd12:   glyph = 7'b1000110;
      5'd13:   glyph = 7'b0100001;
      5'd14:   glyph = 7'b0000110;
      5'd15:   glyph = 7'b0001110;
      5'd16:   glyph = 7'b0000111;
      5'd17:   glyph = 7'b0101111;
      default: glyph = 7'h7F;
    endcase
  end

  // Scan counters, viewer state and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      page_q  <= '0;
      ch_q    <= '0;
      auto_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
    end else begin
      presc_q <= presc_tc ? '0 : presc_q + 1'b1;
      if (presc_tc)
        slot_q <= (slot_q == SW'(NUM_AN - 1)) ? '0 : slot_q + 1'b1;
      frame_q <= frame_d;
      page_q  <= page_d;
      ch_q    <= ch_d;
      auto_q  <= auto_d;
      seg_q   <= glyph;
      an_q    <= an_d;
    end
  end

`ifdef SEG_DP_AUTO_EN
  logic dp_q;

  // Decimal point marks the page digit while auto-scrolling
  always_ff @(posedge clk) begin
    if (rst)
      dp_q <= 1'b1;
    else
      dp_q <= ~(auto_q && (slot_q == SW'(NUM_AN - 2)));
  end

  assign bus.dp = dp_q;
`else
  assign bus.dp = 1'b1;
`endif

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.page_idx = page_q;
  assign bus.ch_idx   = ch_q;
  assign bus.auto_on  = auto_q;
endmodule

// File: tb/tb_seg_buffer_viewer.sv
// Self-checking bench for seg_buffer_viewer: directed sequences, a vector
// table for navigation, and randomized traffic against a timeline model.
module tb_seg_buffer_viewer;
  localparam int DB = 8;
  localparam int FF = 4;
  localparam int NC = 3;
  localparam int RD = 4;
  localparam int AF = 2;
  localparam int NA = DB / 4 + 2;

  logic clk;
  logic rst;
  logic [DB-1:0] mem [NC][FF];

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset release plus viewer status
  int k      = 0;
  int m_page = 0;
  int m_ch   = 0;
  int m_auto = 0;
  int m_frames = 0;

  seg_buffer_viewer_if #(.DATA_BITS(DB), .FIFO(FF), .NUM_CH(NC)) bus ();

  seg_buffer_viewer #(
    .DATA_BITS(DB), .FIFO(FF), .NUM_CH(NC), .REFRESH_DIV(RD), .AUTO_FRAMES(AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.buf_flat = '0;
    for (int c = 0; c < NC; c++)
      for (int e = 0; e < FF; e++)
        bus.buf_flat[(c*FF+e)*DB +: DB] = mem[c][e];
  end

  function automatic logic [6:0] glyph(input int code);
    case (code)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      16: return 7'b0000111;
      17: return 7'b0101111;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
    end
  endtask

  // One clock: predict the registered outputs, advance the model, compare
  task automatic tick();
    int slot;
    int code;
    logic [DB-1:0] ent;
    logic [6:0] eseg;
    logic [NA-1:0] ean;
    logic edp;
    bit fe;
    bit man;
    if (rst) begin
      eseg = 7'h7F; ean = '1; edp = 1'b1;
      m_page = 0; m_ch = 0; m_auto = 0; m_frames = 0; k = 0;
    end else begin
      slot = (k / RD) % NA;
      ent  = mem[m_ch][m_page];
      if (slot < DB / 4) code = int'((ent >> (4 * slot)) & 8'h0F);
      else if (slot == NA - 2) code = m_page;
      else code = (m_ch == 0) ? 16 : (m_ch == 1) ? 17 : m_ch;
      eseg = glyph(code);
      ean = '1;
      ean[slot] = 1'b0;
      edp = 1'b1;
`ifdef SEG_DP_AUTO_EN
      if (m_auto != 0 && slot == NA - 2) edp = 1'b0;
`endif
      fe  = ((k + 1) % (RD * NA)) == 0;
      man = bus.btn_prev != bus.btn_next;
      if (man) m_page = bus.btn_next ? (m_page + 1) % FF : (m_page + FF - 1) % FF;
      if (bus.btn_auto) begin
        m_auto = (m_auto == 0) ? 1 : 0;
        m_frames = 0;
      end else if (man) begin
        m_frames = 0;
      end else if (m_auto != 0 && fe) begin
        m_frames++;
        if (m_frames == AF) begin
          m_frames = 0;
          m_page = (m_page + 1) % FF;
        end
      end
      if (bus.btn_ch) m_ch = (m_ch + 1) % NC;
      k++;
    end
    @(posedge clk);
    #1;
    chk("an", int'(bus.an), int'(ean));
    chk("seg", int'(bus.seg), int'(eseg));
    chk("dp", int'(bus.dp), int'(edp));
    chk("page_idx", int'(bus.page_idx), m_page);
    chk("ch_idx", int'(bus.ch_idx), m_ch);
    chk("auto_on", int'(bus.auto_on), m_auto);
    bus.btn_prev = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_ch   = 1'b0;
    bus.btn_auto = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit prev;
    bit next;
    bit ch;
    bit au;
    int page;
    int chn;
    int aon;
  } vec_t;

  vec_t vt [12];
  logic [3:0] scan_an  [4];
  logic [6:0] scan_seg [4];
  logic [6:0] chan_seg [4];

  initial begin
    rst = 1'b1;
    bus.btn_prev = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_ch   = 1'b0;
    bus.btn_auto = 1'b0;
    for (int c = 0; c < NC; c++)
      for (int e = 0; e < FF; e++)
        mem[c][e] = '0;
    mem[0][0] = 8'hA5;
    mem[1][2] = 8'h3C;

    vt[0]  = '{1, 0, 0, 0, 3, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 1, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 1, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 2, 0, 0};
    vt[5]  = '{0, 0, 1, 0, 2, 1, 0};
    vt[6]  = '{0, 1, 1, 0, 3, 2, 0};
    vt[7]  = '{0, 1, 0, 0, 0, 2, 0};
    vt[8]  = '{0, 0, 1, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 1, 0, 0, 1};
    vt[10] = '{0, 0, 0, 1, 0, 0, 0};
    vt[11] = '{1, 0, 1, 0, 3, 1, 0};

    scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    scan_seg = '{7'b0010010, 7'b0001000, 7'b1000000, 7'b0000111};
    chan_seg = '{7'b1000110, 7'b0110000, 7'b0100100, 7'b0101111};

    // Reset held three cycles
    repeat (3) tick();
    chk("rst_an", int'(bus.an), 4'b1111);
    chk("rst_seg", int'(bus.seg), 7'h7F);
    chk("rst_dp", int'(bus.dp), 1);
    chk("rst_page", int'(bus.page_idx), 0);
    chk("rst_ch", int'(bus.ch_idx), 0);
    rst = 1'b0;

    // One full frame of ch0 entry0 = A5
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("scan_an", int'(bus.an), int'(scan_an[i / 4]));
      chk("scan_seg", int'(bus.seg), int'(scan_seg[i / 4]));
    end

    // Navigation vectors from a fresh reset
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.btn_prev = vt[i].prev;
      bus.btn_next = vt[i].next;
      bus.btn_ch   = vt[i].ch;
      bus.btn_auto = vt[i].au;
      tick();
      chk("vec_page", int'(bus.page_idx), vt[i].page);
      chk("vec_ch", int'(bus.ch_idx), vt[i].chn);
      chk("vec_auto", int'(bus.auto_on), vt[i].aon);
    end

    // Channel 1, page 2 shows 3C with tag r
    do_reset();
    bus.btn_next = 1'b1; tick();
    bus.btn_next = 1'b1; tick();
    bus.btn_ch = 1'b1; tick();
    for (int i = 0; i < 16 && (k % 16) != 0; i++) tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("chan_seg", int'(bus.seg), int'(chan_seg[i / 4]));
    end
    chk("chan_page", int'(bus.page_idx), 2);

    // Auto-scroll: step every 32 cycles
    do_reset();
    bus.btn_auto = 1'b1; tick();
    for (int e = 1; e < 64; e++) begin
      tick();
      if (e == 30) chk("auto_p30", int'(bus.page_idx), 0);
      if (e == 31) chk("auto_p31", int'(bus.page_idx), 1);
      if (e == 62) chk("auto_p62", int'(bus.page_idx), 1);
      if (e == 63) chk("auto_p63", int'(bus.page_idx), 2);
    end

    // Auto-scroll with a manual next at cycle 20 restarting the frame count
    do_reset();
    bus.btn_auto = 1'b1; tick();
    for (int e = 1; e < 48; e++) begin
      if (e == 20) bus.btn_next = 1'b1;
      tick();
      if (e == 20) chk("man_p20", int'(bus.page_idx), 1);
      if (e == 46) chk("man_p46", int'(bus.page_idx), 1);
      if (e == 47) chk("man_p47", int'(bus.page_idx), 2);
    end

    // Randomized traffic including occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      bus.btn_prev = ($urandom_range(0, 63) == 0);
      bus.btn_next = ($urandom_range(0, 63) == 0);
      bus.btn_ch   = ($urandom_range(0, 31) == 0);
      bus.btn_auto = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0)
        mem[$urandom_range(0, NC - 1)][$urandom_range(0, FF - 1)] = DB'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
